// File: rtl/main_mem_responder_if.sv
// Main-memory bus between cache controller and memory slave.
// master drives address/data/requests; slave returns line and ready.
interface main_mem_responder_if;
  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;

  modport master (
    output main_mem_addr,
    output main_mem_data_out,
    output main_mem_read_req,
    output main_mem_write_req,
    input  main_mem_data_in,
    input  main_mem_ready
  );

  modport slave (
    input  main_mem_addr,
    input  main_mem_data_out,
    input  main_mem_read_req,
    input  main_mem_write_req,
    output main_mem_data_in,
    output main_mem_ready
  );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory slave: 64-byte line reads, 32-bit word
// writes into a line-organised store, one-cycle ready pulse.
// Ports: clk, rst (sync, active-high), mm (slave modport), busy.
// Define MAIN_MEM_STATS_EN to add saturating rd_count/wr_count.
module main_mem_responder #(
  parameter int IDX_W     = 8,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  main_mem_responder_if.slave        mm,
  output logic                       busy
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0]                rd_count,
  output logic [15:0]                wr_count
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam logic [7:0] RD_LAST = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_LAST = 8'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             rd_go;
  logic             wr_go;
  logic             rd_done;
  logic             wr_done;

  logic [IDX_W-1:0] idx_q;
  logic [3:0]       wsel_q;
  logic [31:0]      wdata_q;
  logic             ready_q;
  logic [511:0]     line_q;

  logic [511:0]     mem [LINES];

  // Byte offset bits and the bits above the store size only alias.
  logic unused_addr;
  assign unused_addr = ^{mm.main_mem_addr[31:6+IDX_W],
                         mm.main_mem_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Read has priority; a simultaneous write is dropped.
        if (mm.main_mem_read_req) begin
          rd_go   = 1'b1;
          state_d = RD_WAIT;
        end else if (mm.main_mem_write_req) begin
          wr_go   = 1'b1;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          rd_done = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == WR_LAST) begin
          wr_done = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= rd_done | wr_done;
      if (rd_done) begin
        line_q <= mem[idx_q];
      end
    end
  end

  // Request fields are captured only on acceptance.
  always_ff @(posedge clk) begin
    if (rd_go || wr_go) begin
      idx_q <= mm.main_mem_addr[6+IDX_W-1:6];
    end
    if (wr_go) begin
      wsel_q  <= mm.main_mem_addr[5:2];
      wdata_q <= mm.main_mem_data_out;
    end
  end

  // Store is never cleared; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (!rst && wr_done) begin
      mem[idx_q][{wsel_q, 5'b0} +: 32] <= wdata_q;
    end
  end

  assign mm.main_mem_ready   = ready_q;
  assign mm.main_mem_data_in = line_q;
  assign busy = (state_q != IDLE) || ready_q;

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_done && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wr_done && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule
